// File: rtl/elau_gray_pkg.sv
// Bit-slice arithmetic shared by the Gray-to-binary pipeline and its stages.
// Stage 0 takes the topmost CHUNK bits; later stages walk down towards bit 0.
package elau_gray_pkg;

    function automatic int chunk_size(input int width, input int stages);
        int st;
        st = (stages < 1) ? 1 : stages;
        return (width + st - 1) / st;
    endfunction

    // May return a value below stage_lo for trailing stages with nothing left to resolve
    function automatic int stage_hi(input int width, input int stages, input int s);
        return width - 1 - s * chunk_size(width, stages);
    endfunction

    function automatic int stage_lo(input int width, input int stages, input int s);
        int lo;
        lo = width - (s + 1) * chunk_size(width, stages);
        return (lo < 0) ? 0 : lo;
    endfunction

endpackage

// File: rtl/gray2bin_stage.sv
// One elastic register slice resolving Gray bits [HI:LO] seeded by bit HI+1; latency 1.
// Holds its word while downstream stalls; accepts whenever empty or draining.
module gray2bin_stage
    import elau_gray_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HI    = 7,
    parameter int LO    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [WIDTH-1:0] i_dat,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_dat
);

    logic             r_vld;
    logic [WIDTH-1:0] r_dat;
    logic [WIDTH-1:0] w_conv;
    logic             w_acc;

    // Running XOR walks MSB to LSB; the bit above the range is already binary
    always_comb begin
        w_conv = i_dat;
        w_acc  = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i == HI + 1) begin
                w_acc = i_dat[i];
            end
            if (i <= HI && i >= LO) begin
                w_acc     = w_acc ^ i_dat[i];
                w_conv[i] = w_acc;
            end
        end
    end

    assign o_rdy = !r_vld || i_rdy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (o_rdy) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_dat <= w_conv;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;

endmodule

// File: rtl/gray2bin_pipe.sv
// Pipelined Gray-to-binary converter; latency STAGES cycles, one word per cycle.
// Ready ripples back through the stages; a full pipe with out_ready_i low refuses input.
module gray2bin_pipe
    import elau_gray_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_gray_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_bin_o
);

    generate
        if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_cfg
            $error("gray2bin_pipe: need WIDTH >= 1 and 1 <= STAGES <= WIDTH");
        end
    endgenerate

    logic             w_vld [0:STAGES];
    logic             w_rdy [0:STAGES];
    logic [WIDTH-1:0] w_dat [0:STAGES];

    assign w_vld[0]      = in_valid_i;
    assign w_dat[0]      = in_gray_i;
    assign w_rdy[STAGES] = out_ready_i;

    genvar s;
    generate
        for (s = 0; s < STAGES; s++) begin : g_stage
            gray2bin_stage #(
                .WIDTH (WIDTH),
                .HI    (stage_hi(WIDTH, STAGES, s)),
                .LO    (stage_lo(WIDTH, STAGES, s))
            ) u_stage (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .i_vld (w_vld[s]),
                .o_rdy (w_rdy[s]),
                .i_dat (w_dat[s]),
                .o_vld (w_vld[s+1]),
                .i_rdy (w_rdy[s+1]),
                .o_dat (w_dat[s+1])
            );
        end
    endgenerate

    // Words offered during reset are dropped by the stages, so ready may stay high
    assign in_ready_o  = rst_i || w_rdy[0];
    assign out_valid_o = w_vld[STAGES];
    assign out_bin_o   = w_dat[STAGES];

endmodule

// File: tb/tb_gray2bin_pipe.sv
module tb_gray2bin_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // a: WIDTH 8 / STAGES 2, b: 8/1, c: 8/8, d: 1/1, e: 13/4
    logic       a_iv = 0, a_ir, a_ov, a_or = 1;
    logic [7:0] a_ig = 0, a_ob;
    logic       b_iv = 0, b_ir, b_ov, b_or = 1;
    logic [7:0] b_ig = 0, b_ob;
    logic       c_iv = 0, c_ir, c_ov, c_or = 1;
    logic [7:0] c_ig = 0, c_ob;
    logic       d_iv = 0, d_ir, d_ov, d_or = 1;
    logic [0:0] d_ig = 0, d_ob;
    logic        e_iv = 0, e_ir, e_ov, e_or = 1;
    logic [12:0] e_ig = 0, e_ob;

    gray2bin_pipe #(.WIDTH(8), .STAGES(2)) u_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(a_iv), .in_ready_o(a_ir), .in_gray_i(a_ig),
        .out_valid_o(a_ov), .out_ready_i(a_or), .out_bin_o(a_ob));
    gray2bin_pipe #(.WIDTH(8), .STAGES(1)) u_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(b_iv), .in_ready_o(b_ir), .in_gray_i(b_ig),
        .out_valid_o(b_ov), .out_ready_i(b_or), .out_bin_o(b_ob));
    gray2bin_pipe #(.WIDTH(8), .STAGES(8)) u_c (
        .clk_i(clk), .rst_i(rst), .in_valid_i(c_iv), .in_ready_o(c_ir), .in_gray_i(c_ig),
        .out_valid_o(c_ov), .out_ready_i(c_or), .out_bin_o(c_ob));
    gray2bin_pipe #(.WIDTH(1), .STAGES(1)) u_d (
        .clk_i(clk), .rst_i(rst), .in_valid_i(d_iv), .in_ready_o(d_ir), .in_gray_i(d_ig),
        .out_valid_o(d_ov), .out_ready_i(d_or), .out_bin_o(d_ob));
    gray2bin_pipe #(.WIDTH(13), .STAGES(4)) u_e (
        .clk_i(clk), .rst_i(rst), .in_valid_i(e_iv), .in_ready_o(e_ir), .in_gray_i(e_ig),
        .out_valid_o(e_ov), .out_ready_i(e_or), .out_bin_o(e_ob));

    function automatic logic [7:0] to_gray8(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [12:0] g2b13(input logic [12:0] g);
        logic [12:0] b;
        b[12] = g[12];
        for (int i = 11; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic test_reset;
        rst = 1; a_iv = 1; a_ig = 8'h07; a_or = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL reset_ov got=%0b want=0", a_ov); end
            total++; if (a_ob !== 8'h00) begin bad++; $display("FAIL reset_ob got=%0h want=0", a_ob); end
            total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL reset_ir got=%0b want=1", a_ir); end
        end
        @(negedge clk); rst = 0; a_iv = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL post_reset_ov cyc=%0d got=%0b want=0", c, a_ov); end
        end
    endtask

    task automatic test_single;
        @(negedge clk); a_iv = 1; a_ig = 8'h07; a_or = 1; #1;
        total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL single_ir got=%0b want=1", a_ir); end
        @(negedge clk); a_iv = 0; #1;
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL single_c1 got=%0b want=0", a_ov); end
        @(negedge clk); #1;
        total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL single_c2_ov got=%0b want=1", a_ov); end
        total++; if (a_ob !== 8'h05) begin bad++; $display("FAIL single_c2_ob got=%0h want=05", a_ob); end
        @(negedge clk); #1;
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL single_c3 got=%0b want=0", a_ov); end
    endtask

    task automatic test_stream;
        for (int cyc = 0; cyc < 260; cyc++) begin
            @(negedge clk);
            a_or = 1;
            a_iv = (cyc < 256);
            a_ig = to_gray8(cyc[7:0]);
            #1;
            if (cyc < 256) begin
                total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL stream_ir cyc=%0d got=%0b want=1", cyc, a_ir); end
            end
            if (cyc >= 2 && cyc < 258) begin
                total++; if (a_ov !== 1'b1 || a_ob !== 8'(cyc - 2))
                    begin bad++; $display("FAIL stream_out cyc=%0d got=%0b/%0h want=1/%0h", cyc, a_ov, a_ob, 8'(cyc - 2)); end
            end else begin
                total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL stream_idle cyc=%0d got=%0b want=0", cyc, a_ov); end
            end
        end
        a_iv = 0;
    endtask

    task automatic test_backpressure;
        int sent, got;
        logic ir_exp;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
            @(negedge clk);
            a_or = !(cyc >= 6 && cyc < 11);
            a_iv = (sent < 20);
            a_ig = to_gray8(8'h40 + 8'(sent));
            #1;
            ir_exp = ((sent - got) < 2) || a_or;
            total++; if (a_ir !== ir_exp) begin bad++; $display("FAIL bp_ir cyc=%0d got=%0b want=%0b", cyc, a_ir, ir_exp); end
            if (cyc >= 2) begin
                total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL bp_gap cyc=%0d got=%0b want=1", cyc, a_ov); end
            end
            if (a_ov === 1'b1) begin
                total++; if (a_ob !== 8'h40 + 8'(got))
                    begin bad++; $display("FAIL bp_data cyc=%0d got=%0h want=%0h", cyc, a_ob, 8'h40 + 8'(got)); end
                if (a_or) got++;
            end
            if (a_iv && a_ir === 1'b1) sent++;
        end
        total++; if (got != 20) begin bad++; $display("FAIL bp_count got=%0d want=20", got); end
        @(negedge clk); a_iv = 0; a_or = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk); a_iv = 1; a_ig = to_gray8(8'hA0); a_or = 1;
        @(negedge clk); a_ig = to_gray8(8'hA1);
        @(negedge clk); rst = 1; a_or = 0; a_ig = to_gray8(8'hA2); #1;
        total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL rmid_ir got=%0b want=1", a_ir); end
        @(negedge clk); #1;
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL rmid_ov got=%0b want=0", a_ov); end
        total++; if (a_ob !== 8'h00) begin bad++; $display("FAIL rmid_ob got=%0h want=0", a_ob); end
        rst = 0; a_or = 1; a_iv = 1; a_ig = 8'h22;
        @(negedge clk); a_iv = 0; #1;
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL rmid_c1 got=%0b want=0", a_ov); end
        @(negedge clk); #1;
        total++; if (a_ov !== 1'b1 || a_ob !== 8'h3C)
            begin bad++; $display("FAIL rmid_first got=%0b/%0h want=1/3c", a_ov, a_ob); end
        @(negedge clk); #1;
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL rmid_after got=%0b want=0", a_ov); end
    endtask

    task automatic test_stages1;
        int lat; logic [7:0] cap;
        lat = -1; cap = 8'h00;
        @(negedge clk); b_iv = 1; b_ig = 8'h80; b_or = 1; #1;
        total++; if (b_ir !== 1'b1) begin bad++; $display("FAIL s1_ir got=%0b want=1", b_ir); end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk); b_iv = 0; #1;
            if (b_ov === 1'b1) begin lat = c; cap = b_ob; break; end
        end
        total++; if (lat != 1) begin bad++; $display("FAIL s1_latency got=%0d want=1", lat); end
        total++; if (cap !== 8'hFF) begin bad++; $display("FAIL s1_data got=%0h want=ff", cap); end
    endtask

    task automatic test_stages8;
        int lat; logic [7:0] cap;
        lat = -1; cap = 8'h00;
        @(negedge clk); c_iv = 1; c_ig = 8'h80; c_or = 1; #1;
        total++; if (c_ir !== 1'b1) begin bad++; $display("FAIL s8_ir got=%0b want=1", c_ir); end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk); c_iv = 0; #1;
            if (c_ov === 1'b1) begin lat = c; cap = c_ob; break; end
        end
        total++; if (lat != 8) begin bad++; $display("FAIL s8_latency got=%0d want=8", lat); end
        total++; if (cap !== 8'hFF) begin bad++; $display("FAIL s8_data got=%0h want=ff", cap); end
    endtask

    task automatic test_width1;
        int lat; logic [0:0] cap;
        lat = -1; cap = 1'b0;
        @(negedge clk); d_iv = 1; d_ig = 1'b1; d_or = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); d_iv = 0; #1;
            if (d_ov === 1'b1) begin lat = c; cap = d_ob; break; end
        end
        total++; if (lat != 1) begin bad++; $display("FAIL w1_latency got=%0d want=1", lat); end
        total++; if (cap !== 1'b1) begin bad++; $display("FAIL w1_data got=%0b want=1", cap); end
    endtask

    task automatic test_width13;
        logic [12:0] g [40];
        int sent, got;
        sent = 0; got = 0;
        g[0] = 13'h1000; g[1] = 13'h1FFF; g[2] = 13'h0001;
        for (int i = 3; i < 40; i++) g[i] = 13'($urandom);
        for (int cyc = 0; cyc < 600 && got < 40; cyc++) begin
            @(negedge clk);
            e_or = ($urandom_range(0, 3) != 0);
            e_iv = (sent < 40) && ($urandom_range(0, 3) != 0);
            e_ig = g[(sent < 40) ? sent : 39];
            #1;
            if (e_ov === 1'b1 && e_or) begin
                total++; if (e_ob !== g2b13(g[got]))
                    begin bad++; $display("FAIL w13_data idx=%0d got=%0h want=%0h", got, e_ob, g2b13(g[got])); end
                got++;
            end
            if (e_iv && e_ir === 1'b1) sent++;
        end
        total++; if (got != 40) begin bad++; $display("FAIL w13_count got=%0d want=40", got); end
        e_iv = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_stages1();
        test_stages8();
        test_width1();
        test_width13();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
